// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO for the FIR sample path.
// Owns the storage array, the read/write pointers and the occupancy count.
// The read port is registered and carries a valid strobe. Status flags are
// compares on the registered count. Error pulses are registered.
module sync_fifo #(
    parameter int DATA_SIZE     = 8,
    parameter int ADDR_SIZE     = 4,
    parameter int AFULL_THRESH  = (1 << ADDR_SIZE) - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic                 rd_en,
    output logic [DATA_SIZE-1:0] rdata,
    output logic                 rvalid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int DEPTH = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] DEPTH_CNT  = (ADDR_SIZE + 1)'(DEPTH);
    localparam logic [ADDR_SIZE:0] AFULL_CNT  = (ADDR_SIZE + 1)'(AFULL_THRESH);
    localparam logic [ADDR_SIZE:0] AEMPTY_CNT = (ADDR_SIZE + 1)'(AEMPTY_THRESH);
    localparam logic [ADDR_SIZE:0] CNT_ONE    = (ADDR_SIZE + 1)'(1);
    localparam logic [ADDR_SIZE-1:0] PTR_ONE  = ADDR_SIZE'(1);

    logic [DATA_SIZE-1:0] mem_q [DEPTH];

    logic [ADDR_SIZE-1:0] wptr_q, wptr_d;
    logic [ADDR_SIZE-1:0] rptr_q, rptr_d;
    logic [ADDR_SIZE:0]   count_q, count_d;
    logic [DATA_SIZE-1:0] rdata_q, rdata_d;
    logic                 rvalid_q, rvalid_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;
    logic                 wr_acc;
    logic                 rd_acc;

    // Flags are pure compares on the registered count so they move on the
    // same edge as the pointers.
    always_comb begin
        full         = (count_q == DEPTH_CNT);
        empty        = (count_q == '0);
        almost_full  = (count_q >= AFULL_CNT);
        almost_empty = (count_q <= AEMPTY_CNT);
    end

    // Next-state: request acceptance, pointer/count update, read port and
    // error pulses. A write at full is taken only when a read frees a slot.
    always_comb begin
        wr_acc      = wr_en && (!full || rd_en);
        rd_acc      = rd_en && !empty;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        overflow_d  = wr_en && !wr_acc;
        underflow_d = rd_en && empty;

        if (wr_acc) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rptr_d   = rptr_q + PTR_ONE;
            rdata_d  = mem_q[rptr_q];
            rvalid_d = 1'b1;
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control and read-port registers; reset drops all stored data and
    // suppresses error pulses for requests made during reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage write; not cleared by reset. When full with a simultaneous
    // read, wptr == rptr and the read port still sees the old word because
    // both updates land on the same edge.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (DEPTH=16, AFULL_THRESH=14, AEMPTY_THRESH=2).
// Each record gives the inputs applied before one rising edge and the
// outputs expected just after it; flags are derived from the expected count.
module tb_sync_fifo;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wdata;
    logic       rd_en;
    logic [7:0] rdata;
    logic       rvalid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic       rst_n;
        logic       wr_en;
        logic       rd_en;
        logic [7:0] wdata;
        int         count;
        logic       rvalid;
        logic [7:0] rdata;
        logic       ovf;
        logic       udf;
    } vec_t;

    vec_t vecs[$];

    sync_fifo #(
        .DATA_SIZE    (8),
        .ADDR_SIZE    (4),
        .AFULL_THRESH (14),
        .AEMPTY_THRESH(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wdata       (wdata),
        .rd_en       (rd_en),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic w, input logic rd,
                                input logic [7:0] wd, input int cnt,
                                input logic rv, input logic [7:0] rdv,
                                input logic o, input logic u);
        vec_t v;
        v.rst_n  = r;
        v.wr_en  = w;
        v.rd_en  = rd;
        v.wdata  = wd;
        v.count  = cnt;
        v.rvalid = rv;
        v.rdata  = rdv;
        v.ovf    = o;
        v.udf    = u;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        rst_n = v.rst_n;
        wr_en = v.wr_en;
        rd_en = v.rd_en;
        wdata = v.wdata;
        @(posedge clk);
        #1;
        chk({tag, " count"},        int'(count),        v.count);
        chk({tag, " empty"},        int'(empty),        int'(v.count == 0));
        chk({tag, " full"},         int'(full),         int'(v.count == 16));
        chk({tag, " almost_full"},  int'(almost_full),  int'(v.count >= 14));
        chk({tag, " almost_empty"}, int'(almost_empty), int'(v.count <= 2));
        chk({tag, " rvalid"},       int'(rvalid),       int'(v.rvalid));
        chk({tag, " rdata"},        int'(rdata),        int'(v.rdata));
        chk({tag, " overflow"},     int'(overflow),     int'(v.ovf));
        chk({tag, " underflow"},    int'(underflow),    int'(v.udf));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wdata = 8'h00;

        // Reset with both requests high: no errors, empty state.
        vecs.push_back(mk(0, 1, 1, 8'hFF, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 1, 8'hFF, 0, 0, 8'h00, 0, 0));
        // Fill 0x00..0x0F.
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(1, 1, 0, 8'(i), i + 1, 0, 8'h00, 0, 0));
        // Write while full: dropped, one overflow pulse.
        vecs.push_back(mk(1, 1, 0, 8'hAA, 16, 0, 8'h00, 1, 0));
        vecs.push_back(mk(1, 0, 0, 8'h00, 16, 0, 8'h00, 0, 0));
        // Drain: oldest first, 0xAA never appears.
        for (int j = 0; j < 16; j++)
            vecs.push_back(mk(1, 0, 1, 8'h00, 15 - j, 1, 8'(j), 0, 0));
        // Read while empty: underflow pulse, rdata holds.
        vecs.push_back(mk(1, 0, 1, 8'h00, 0, 0, 8'h0F, 0, 1));
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h0F, 0, 0));

        for (int k = 0; k < vecs.size(); k++)
            apply(vecs[k], $sformatf("vec%0d", k));

        // Simultaneous read/write at full: oldest out, new word pops last.
        for (int i = 0; i < 16; i++)
            apply(mk(1, 1, 0, 8'(8'h10 + i), i + 1, 0, 8'h0F, 0, 0), "s4_fill");
        apply(mk(1, 1, 1, 8'h55, 16, 1, 8'h10, 0, 0), "s4_full_wr_rd");
        for (int i = 0; i < 15; i++)
            apply(mk(1, 0, 1, 8'h00, 15 - i, 1, 8'(8'h11 + i), 0, 0), "s4_drain");
        apply(mk(1, 0, 1, 8'h00, 0, 1, 8'h55, 0, 0), "s4_last_55");

        // Simultaneous at empty: write taken, read rejected, no fall-through.
        apply(mk(1, 1, 1, 8'h33, 1, 0, 8'h55, 0, 1), "s4_empty_wr_rd");
        apply(mk(1, 0, 1, 8'h00, 0, 1, 8'h33, 0, 0), "s4_read_33");

        // Streaming across pointer wrap with one entry in flight.
        apply(mk(1, 1, 0, 8'h80, 1, 0, 8'h33, 0, 0), "s5_seed");
        for (int k = 0; k < 40; k++)
            apply(mk(1, 1, 1, 8'(8'h81 + k), 1, 1, 8'(8'h80 + k), 0, 0), "s5_stream");
        apply(mk(1, 0, 1, 8'h00, 0, 1, 8'hA8, 0, 0), "s5_tail");

        // Reset mid-operation discards contents; next word is fresh.
        for (int i = 0; i < 9; i++)
            apply(mk(1, 1, 0, 8'(8'hC0 + i), i + 1, 0, 8'hA8, 0, 0), "s6_fill");
        apply(mk(0, 1, 1, 8'hEE, 0, 0, 8'h00, 0, 0), "s6_reset");
        apply(mk(1, 1, 0, 8'h77, 1, 0, 8'h00, 0, 0), "s6_write_77");
        apply(mk(1, 0, 1, 8'h00, 0, 1, 8'h77, 0, 0), "s6_read_77");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
